// File: rtl/svga_scan_out.sv
// 800x600@72 SVGA scan-out: frame-buffer fetch addressing plus greyscale DAC drive.
// Optional TEST_PATTERN_EN adds test_mode and an 8-bar colour pattern.
module svga_scan_out #(
  parameter int H_ACTIVE   = 800,
  parameter int H_FP       = 56,
  parameter int H_SYNC     = 120,
  parameter int H_BP       = 64,
  parameter int V_ACTIVE   = 600,
  parameter int V_FP       = 37,
  parameter int V_SYNC     = 6,
  parameter int V_BP       = 23,
  parameter int RD_LATENCY = 2,
  parameter int SYNC_POL   = 1
) (
  input  logic       clk_50,
  input  logic       reset,
  output logic [9:0] x_addr,
  output logic [9:0] y_addr,
  input  logic [7:0] value,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vga_sync_n,
`ifdef TEST_PATTERN_EN
  input  logic       test_mode,
`endif
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_ON  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC - 1);

  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] VS_ON  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam logic SYNC_ON = (SYNC_POL != 0);

  logic [10:0] h_cnt;
  logic [9:0]  v_cnt;
  logic        h_in, v_in;
  logic        act_f, hs_f, vs_f;
  logic        act_d, hs_d, vs_d;

  logic [RD_LATENCY-1:0] act_sr, hs_sr, vs_sr;

  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 11'd1;
    end
  end

  always_comb begin
    h_in   = (h_cnt < H_ACT);
    v_in   = (v_cnt < V_ACT);
    act_f  = h_in && v_in;
    hs_f   = (h_cnt >= HS_ON) && (h_cnt <= HS_END);
    vs_f   = (v_cnt >= VS_ON) && (v_cnt <= VS_END);
    x_addr = h_in ? h_cnt[9:0] : 10'd0;
    y_addr = v_in ? v_cnt : 10'd0;
  end

  // Flags ride alongside the read so they meet value at the output register
  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      act_sr <= '0;
      hs_sr  <= '0;
      vs_sr  <= '0;
    end else begin
      act_sr[0] <= act_f;
      hs_sr[0]  <= hs_f;
      vs_sr[0]  <= vs_f;
      for (int i = 1; i < RD_LATENCY; i++) begin
        act_sr[i] <= act_sr[i-1];
        hs_sr[i]  <= hs_sr[i-1];
        vs_sr[i]  <= vs_sr[i-1];
      end
    end
  end

  assign act_d = act_sr[RD_LATENCY-1];
  assign hs_d  = hs_sr[RD_LATENCY-1];
  assign vs_d  = vs_sr[RD_LATENCY-1];

`ifdef TEST_PATTERN_EN
  logic [2:0] bar_f;
  logic [2:0] bar_sr [RD_LATENCY];
  logic [2:0] bar_d;

  always_comb begin
    bar_f = 3'd0;
    for (int i = 1; i < 8; i++)
      if (h_cnt >= 11'(i * 100)) bar_f = 3'(i);
  end

  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RD_LATENCY; i++) bar_sr[i] <= '0;
    end else begin
      bar_sr[0] <= bar_f;
      for (int i = 1; i < RD_LATENCY; i++) bar_sr[i] <= bar_sr[i-1];
    end
  end

  assign bar_d = bar_sr[RD_LATENCY-1];
`endif

  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_blank_n <= 1'b0;
      vga_hs      <= ~SYNC_ON;
      vga_vs      <= ~SYNC_ON;
      frame_start <= 1'b0;
    end else begin
      vga_blank_n <= act_d;
      vga_hs      <= hs_d ? SYNC_ON : ~SYNC_ON;
      vga_vs      <= vs_d ? SYNC_ON : ~SYNC_ON;
      frame_start <= (h_cnt == 11'd0) && (v_cnt == 10'd0);
      vga_r       <= act_d ? value : 8'd0;
      vga_g       <= act_d ? value : 8'd0;
      vga_b       <= act_d ? value : 8'd0;
`ifdef TEST_PATTERN_EN
      // Bar index order white..black maps to inverted bits {1,2,0}
      if (act_d && test_mode) begin
        vga_r <= {8{~bar_d[1]}};
        vga_g <= {8{~bar_d[2]}};
        vga_b <= {8{~bar_d[0]}};
      end
`endif
    end
  end

  assign vga_sync_n = 1'b0;

endmodule

// File: tb/tb_svga_scan_out.sv
// Directed bench for svga_scan_out; vertical timing shrunk to 8 lines per frame
// so several frames fit in a short run. Horizontal timing is the real 1040.
module tb_svga_scan_out;

  logic       clk_50 = 1'b0;
  logic       reset  = 1'b0;
  logic [9:0] x_addr, y_addr;
  logic [7:0] value;
  logic [7:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs, vga_blank_n, vga_sync_n, frame_start;
  logic       test_mode = 1'b0;

  logic [7:0] p1, p2;
  logic       junk = 1'b0;
  int         k = 0;
  int         n_vec = 0;
  int         n_err = 0;
  int         hs_hits;

  always #10 clk_50 = ~clk_50;

  svga_scan_out #(
    .V_ACTIVE(4), .V_FP(2), .V_SYNC(1), .V_BP(1)
  ) dut (
    .clk_50(clk_50),
    .reset(reset),
    .x_addr(x_addr),
    .y_addr(y_addr),
    .value(value),
    .vga_r(vga_r),
    .vga_g(vga_g),
    .vga_b(vga_b),
    .vga_hs(vga_hs),
    .vga_vs(vga_vs),
    .vga_blank_n(vga_blank_n),
    .vga_sync_n(vga_sync_n),
`ifdef TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .frame_start(frame_start)
  );

  // Two-cycle-latency frame buffer returning (x+y)[7:0]
  always @(posedge clk_50) begin
    p1 <= 8'(x_addr + y_addr);
    p2 <= p1;
  end
  assign value = junk ? 8'hFF : p2;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_50);
    #1;
    k++;
  endtask

  task automatic at(input int t);
    while (k < t) step();
  endtask

  task automatic quiet_hs(input int t);
    hs_hits = 0;
    while (k < t) begin
      step();
      if (vga_hs) hs_hits++;
    end
    chk("hs_quiet", hs_hits, 0);
  endtask

  initial begin
    repeat (4) @(posedge clk_50);
    #1;
    chk("rst_x", x_addr, 0);
    chk("rst_y", y_addr, 0);
    chk("rst_hs", vga_hs, 0);
    chk("rst_vs", vga_vs, 0);
    chk("rst_blank", vga_blank_n, 0);
    chk("rst_rgb", {vga_r, vga_g, vga_b}, 0);
    chk("rst_fs", frame_start, 0);
    chk("sync_n", vga_sync_n, 0);
    @(negedge clk_50);
    reset = 1'b1;
    k = 0;

    at(1);    chk("fs_first", frame_start, 1);
    at(2);    chk("fs_pulse", frame_start, 0);
    at(3);    chk("px00_blank", vga_blank_n, 1);
              chk("px00_r", vga_r, 8'h00);
    at(4);    chk("px10_rgb", {vga_r, vga_g, vga_b}, 24'h010101);
              chk("x_addr4", x_addr, 4);
    at(802);  chk("px799_blank", vga_blank_n, 1);
              chk("px799_r", vga_r, 8'h1F);
    at(803);  chk("px800_blank", vga_blank_n, 0);
              chk("px800_r", vga_r, 0);
    at(900);  junk = 1'b1;
    at(950);  chk("junk_rgb", {vga_r, vga_g, vga_b}, 0);
              chk("blank_x", x_addr, 0);
              chk("blank_y", y_addr, 0);
    at(1000); junk = 1'b0;
    k = k;
    at(1043); chk("px0_1_r", vga_r, 8'h01);
    at(1243); chk("px200_1_r", vga_r, 8'hC9);
              chk("addr_x", x_addr, 203);
              chk("addr_y", y_addr, 1);
    at(3922); chk("px799_3_r", vga_r, 8'h22);
    at(4173); chk("vblank", vga_blank_n, 0);
              chk("vblank_y", y_addr, 0);
    at(6242); chk("vs_pre", vga_vs, 0);
    at(6243); chk("vs_rise", vga_vs, 1);
    at(7282); chk("vs_last", vga_vs, 1);
    at(7283); chk("vs_fall", vga_vs, 0);
    at(8320); chk("fs_pre", frame_start, 0);
    at(8321); chk("fs_period", frame_start, 1);
    at(8323); chk("f2_blank", vga_blank_n, 1);
    at(14562); chk("vs2_pre", vga_vs, 0);
    at(14563); chk("vs2_rise", vga_vs, 1);

    at(19120);
    chk("mid_x", x_addr, 400);
    chk("mid_y", y_addr, 2);
    chk("mid_r", vga_r, 8'h8F);
    reset = 1'b0;
    #2;
    chk("arst_rgb", {vga_r, vga_g, vga_b}, 0);
    chk("arst_blank", vga_blank_n, 0);
    chk("arst_x", x_addr, 0);
    chk("arst_fs", frame_start, 0);
    repeat (3) @(posedge clk_50);
    @(negedge clk_50);
    reset = 1'b1;
    k = 0;
    at(1);    chk("re_fs", frame_start, 1);
    at(4);    chk("re_px", vga_r, 8'h01);

    hs_hits = 0;
    while (k < 858) begin
      step();
      if (vga_hs) hs_hits++;
    end
    chk("hs_quiet", hs_hits, 0);
    at(859);  chk("hs_rise", vga_hs, 1);
    at(978);  chk("hs_last", vga_hs, 1);
    at(979);  chk("hs_fall", vga_hs, 0);
`ifdef TEST_PATTERN_EN
    test_mode = 1'b1;
    at(1093); chk("bar_white", {vga_r, vga_g, vga_b}, 24'hFFFFFF);
    at(1293); chk("bar_cyan", {vga_r, vga_g, vga_b}, 24'h00FFFF);
    at(1793); chk("bar_black", {vga_r, vga_g, vga_b}, 24'h000000);
              chk("bar_blank", vga_blank_n, 1);
`endif
    at(1898); chk("hs2_pre", vga_hs, 0);
    at(1899); chk("hs2_rise", vga_hs, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
